// File: rtl/fpdiv_sched.sv
// fpdiv_sched: round-robin scheduler sharing one iterative single-precision divider among NREQ requesters.
// Define FPDIV_SCHED_BYPASS_EN to resolve NaN/zero/infinity operands locally without starting the divider.
//
// state | meaning
// IDLE  | arbitrating; req_ready raised for the round-robin winner
// ISSUE | one-cycle div_start with the latched operands
// BUSY  | waiting for div_done
// RESP  | response held until resp_ready

module fpdiv_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_n,
    input  logic [32*NREQ-1:0]   req_d,
    input  logic [NREQ-1:0]      req_rm,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [IDW-1:0]       resp_id,
    output logic [31:0]          resp_q,
    output logic                 div_start,
    output logic [31:0]          div_n,
    output logic [31:0]          div_d,
    output logic                 div_rm,
    input  logic                 div_done,
    input  logic [31:0]          div_q
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_BUSY  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  ptr_nx;
    logic [IDW-1:0]  grant;
    logic [IDW-1:0]  id_q;
    logic            grant_vld;
    logic            hs;
    logic [NREQ-1:0] rot;
    logic [31:0]     sel_n;
    logic [31:0]     sel_d;
    logic            sel_rm;
    int              arb_sel;
    int              arb_sum;

`ifdef FPDIV_SCHED_BYPASS_EN
    logic            byp_hit;
    logic [31:0]     byp_q;

    // Priority: invalid (NaN, 0/0, inf/inf), then x/0, then 0/x or x/inf, then inf/x.
    function automatic logic [32:0] bypass_fn(input logic [31:0] n, input logic [31:0] d);
        logic n_nan, d_nan, n_inf, d_inf, n_zero, d_zero, s;
        n_nan  = (&n[30:23]) && (|n[22:0]);
        d_nan  = (&d[30:23]) && (|d[22:0]);
        n_inf  = (&n[30:23]) && !(|n[22:0]);
        d_inf  = (&d[30:23]) && !(|d[22:0]);
        n_zero = !(|n[30:0]);
        d_zero = !(|d[30:0]);
        s      = n[31] ^ d[31];
        if (n_nan || d_nan || (n_zero && d_zero) || (n_inf && d_inf))
            return {1'b1, 32'h7FC00000};
        else if (d_zero)
            return {1'b1, s, 31'h7F800000};
        else if (n_zero || d_inf)
            return {1'b1, s, 31'h00000000};
        else if (n_inf)
            return {1'b1, s, 31'h7F800000};
        else
            return {1'b0, 32'h00000000};
    endfunction

    always_comb begin
        {byp_hit, byp_q} = bypass_fn(sel_n, sel_d);
    end
`endif

    // Rotate so bit 0 belongs to rr_ptr, take the lowest set bit, then rotate the index back.
    always_comb begin
        rot       = NREQ'({req_valid, req_valid} >> rr_ptr);
        grant_vld = |rot;
        arb_sel   = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) arb_sel = k;
        end
        arb_sum = int'(rr_ptr) + arb_sel;
        if (arb_sum >= NREQ) arb_sum = arb_sum - NREQ;
        grant = IDW'(arb_sum);
    end

    always_comb begin
        ptr_nx = (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
    end

    always_comb begin
        req_ready = '0;
        if (reset && state == S_IDLE && grant_vld)
            req_ready = NREQ'(1) << grant;
    end

    assign hs = |(req_valid & req_ready);

    always_comb begin
        sel_n  = '0;
        sel_d  = '0;
        sel_rm = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant == IDW'(k)) begin
                sel_n  = req_n[k*32 +: 32];
                sel_d  = req_d[k*32 +: 32];
                sel_rm = req_rm[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (hs) begin
`ifdef FPDIV_SCHED_BYPASS_EN
                    state_nx = byp_hit ? S_RESP : S_ISSUE;
`else
                    state_nx = S_ISSUE;
`endif
                end
            end
            S_ISSUE: state_nx = S_BUSY;
            S_BUSY:  if (div_done)   state_nx = S_RESP;
            S_RESP:  if (resp_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        div_start  = (state == S_ISSUE);
        resp_valid = (state == S_RESP);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr  <= '0;
            id_q    <= '0;
            div_n   <= '0;
            div_d   <= '0;
            div_rm  <= 1'b0;
            resp_q  <= '0;
            resp_id <= '0;
        end else begin
            if (state == S_IDLE && hs) begin
                div_n  <= sel_n;
                div_d  <= sel_d;
                div_rm <= sel_rm;
                id_q   <= grant;
                rr_ptr <= ptr_nx;
`ifdef FPDIV_SCHED_BYPASS_EN
                if (byp_hit) begin
                    resp_q  <= byp_q;
                    resp_id <= grant;
                end
`endif
            end
            if (state == S_BUSY && div_done) begin
                resp_q  <= div_q;
                resp_id <= id_q;
            end
        end
    end

endmodule

// File: tb/tb_fpdiv_sched.sv
// Directed bench for fpdiv_sched: divider model with fixed latency, scoreboard of expected responses.
// Bypass expectations follow FPDIV_SCHED_BYPASS_EN.

module tb_fpdiv_sched;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int L    = 26;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [32*NREQ-1:0]   req_n;
    logic [32*NREQ-1:0]   req_d;
    logic [NREQ-1:0]      req_rm;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [IDW-1:0]       resp_id;
    logic [31:0]          resp_q;
    logic                 div_start;
    logic [31:0]          div_n;
    logic [31:0]          div_d;
    logic                 div_rm;
    logic                 div_done;
    logic [31:0]          div_q;

    logic [31:0] op_n [NREQ];
    logic [31:0] op_d [NREQ];

    logic        model_en = 1'b1;
    logic        mdl_done = 1'b0;
    logic [31:0] mdl_q = '0;
    logic        mbusy = 1'b0;
    int          mcnt = 0;
    logic        inj_done = 1'b0;
    logic [31:0] inj_q = '0;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          start_cnt = 0;
    logic [33:0] sb [$];
    logic [33:0] sb_e;

    always #5 clk = ~clk;

    assign req_n    = {op_n[3], op_n[2], op_n[1], op_n[0]};
    assign req_d    = {op_d[3], op_d[2], op_d[1], op_d[0]};
    assign div_done = mdl_done | inj_done;
    assign div_q    = inj_done ? inj_q : mdl_q;

    fpdiv_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_n(req_n), .req_d(req_d), .req_rm(req_rm),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_q(resp_q),
        .div_start(div_start), .div_n(div_n), .div_d(div_d), .div_rm(div_rm),
        .div_done(div_done), .div_q(div_q)
    );

    function automatic logic [31:0] q_model(input logic [31:0] n, input logic [31:0] d);
        case ({n, d})
            {32'h3FC00000, 32'h3F800000}: return 32'h3FC00000;
            {32'h40C00000, 32'h40000000}: return 32'h40400000;
            {32'h40000000, 32'h3F800000}: return 32'h40000000;
            {32'h3F800000, 32'h00000000}: return 32'h7F800000;
            default:                      return 32'hDEADBEEF;
        endcase
    endfunction

    // Divider: start seen in cycle S gives done in cycle S+L.
    always @(posedge clk) begin
        mdl_done <= 1'b0;
        if (!reset) begin
            mbusy <= 1'b0;
            mcnt  <= 0;
        end else if (div_start) begin
            mbusy <= 1'b1;
            mcnt  <= L - 1;
            mdl_q <= q_model(div_n, div_d);
        end else if (mbusy) begin
            if (mcnt == 1) begin
                mdl_done <= model_en;
                mbusy    <= 1'b0;
            end
            mcnt <= mcnt - 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            n_cmp++;
            assert ($onehot0(req_ready)) else begin
                n_bad++;
                $error("FAIL ready_onehot: observed %b expected at most one bit", req_ready);
            end
            for (int k = 0; k < NREQ; k++) begin
                if (req_valid[k] && req_ready[k])
                    sb.push_back({2'(k), q_model(op_n[k], op_d[k])});
            end
            if (resp_valid && resp_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_resp", 32'(resp_valid), 32'd0);
                end else begin
                    sb_e = sb.pop_front();
                    chk("sb_resp_id", 32'(resp_id), 32'(sb_e[33:32]));
                    chk("sb_resp_q", resp_q, sb_e[31:0]);
                end
            end
            if (div_start) start_cnt++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic wait_grant(input logic [NREQ-1:0] exp, input string tag);
        int n;
        n = 0;
        smp();
        while (req_ready == '0 && n < 100) begin
            cyc();
            smp();
            n++;
        end
        chk(tag, 32'(req_ready), 32'(exp));
    endtask

    task automatic wait_lat(output int lat);
        lat = 1;
        while (!resp_valid && lat < 100) begin
            cyc();
            smp();
            lat++;
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        resp_ready = 1'b1;
        cyc();
        while ((sb.size() != 0 || resp_valid) && n < 500) begin
            cyc();
            n++;
        end
        chk(tag, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int s0;

        reset      = 1'b0;
        req_valid  = '1;
        req_rm     = '0;
        resp_ready = 1'b1;
        for (int k = 0; k < NREQ; k++) begin
            op_n[k] = 32'h40C00000;
            op_d[k] = 32'h40000000;
        end

        cyc();
        cyc();
        smp();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_div_start", 32'(div_start), 32'd0);
        chk("rst_resp_q", resp_q, 32'd0);
        chk("rst_resp_id", 32'(resp_id), 32'd0);
        chk("rst_div_n", div_n, 32'd0);
        chk("rst_div_d", div_d, 32'd0);
        chk("rst_div_rm", 32'(div_rm), 32'd0);
        cyc();
        reset     = 1'b1;
        req_valid = '0;

        // single op, latency
        cyc();
        op_n[0]   = 32'h3FC00000;
        op_d[0]   = 32'h3F800000;
        req_valid = 4'b0001;
        s0        = start_cnt;
        smp();
        chk("t1_ready", 32'(req_ready), 32'h1);
        cyc();
        req_valid = '0;
        smp();
        chk("t1_div_start", 32'(div_start), 32'd1);
        chk("t1_div_n", div_n, 32'h3FC00000);
        chk("t1_div_d", div_d, 32'h3F800000);
        chk("t1_ready_issue", 32'(req_ready), 32'd0);
        wait_lat(lat);
        chk("t1_latency", 32'(lat), 32'd28);
        chk("t1_resp_q", resp_q, 32'h3FC00000);
        chk("t1_resp_id", 32'(resp_id), 32'd0);
        cyc();
        chk("t1_start_pulses", 32'(start_cnt - s0), 32'd1);
        drain("t1_drain");

        // fairness from reset, all requesters valid
        reset = 1'b0;
        cyc();
        reset     = 1'b1;
        op_n[0]   = 32'h40C00000;
        op_d[0]   = 32'h40000000;
        sb.delete();
        req_valid = 4'b1111;
        wait_grant(4'b0001, "t2_grant0");
        cyc();
        wait_grant(4'b0010, "t2_grant1");
        cyc();
        wait_grant(4'b0100, "t2_grant2");
        cyc();
        wait_grant(4'b1000, "t2_grant3");
        cyc();
        wait_grant(4'b0001, "t2_grant4");
        cyc();
        req_valid = '0;
        drain("t2_drain");

        // backpressure on the response
        resp_ready = 1'b0;
        op_n[1]    = 32'h3FC00000;
        op_d[1]    = 32'h3F800000;
        req_valid  = 4'b0010;
        wait_grant(4'b0010, "t3_grant1");
        cyc();
        req_valid = '0;
        smp();
        wait_lat(lat);
        chk("t3_resp_valid", 32'(resp_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            cyc();
            req_valid = 4'b0100;
            smp();
            chk("t3_hold_valid", 32'(resp_valid), 32'd1);
            chk("t3_hold_q", resp_q, 32'h3FC00000);
            chk("t3_hold_id", 32'(resp_id), 32'd1);
            chk("t3_hold_ready", 32'(req_ready), 32'd0);
            chk("t3_hold_start", 32'(div_start), 32'd0);
        end
        cyc();
        req_valid  = '0;
        resp_ready = 1'b1;
        smp();
        chk("t3_accept_cycle", 32'(resp_valid), 32'd1);
        cyc();
        smp();
        chk("t3_released", 32'(resp_valid), 32'd0);

        // reset while BUSY, then a stray div_done
        op_n[2]   = 32'h40000000;
        op_d[2]   = 32'h3F800000;
        cyc();
        req_valid = 4'b0100;
        wait_grant(4'b0100, "t4_grant2");
        cyc();
        req_valid = '0;
        cyc();
        cyc();
        cyc();
        model_en = 1'b0;
        reset    = 1'b0;
        cyc();
        reset = 1'b1;
        smp();
        chk("t4_div_n", div_n, 32'd0);
        chk("t4_div_d", div_d, 32'd0);
        chk("t4_resp_valid", 32'(resp_valid), 32'd0);
        chk("t4_div_start", 32'(div_start), 32'd0);
        cyc();
        sb.delete();
        inj_q    = 32'h12345678;
        inj_done = 1'b1;
        smp();
        chk("t4_stray_done", 32'(resp_valid), 32'd0);
        cyc();
        inj_done = 1'b0;
        model_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            smp();
            chk("t4_no_resp", 32'(resp_valid), 32'd0);
            cyc();
        end
        req_valid = 4'b0101;
        wait_grant(4'b0001, "t4_grant0");
        cyc();
        req_valid = '0;
        drain("t4_drain");

        // divide by zero from requester 2
        op_n[2]   = 32'h3F800000;
        op_d[2]   = 32'h00000000;
        s0        = start_cnt;
        req_valid = 4'b0100;
        wait_grant(4'b0100, "t5_grant2");
        cyc();
        req_valid = '0;
        smp();
`ifdef FPDIV_SCHED_BYPASS_EN
        chk("t5_byp_resp_valid", 32'(resp_valid), 32'd1);
        chk("t5_byp_div_start", 32'(div_start), 32'd0);
        chk("t5_byp_resp_q", resp_q, 32'h7F800000);
        chk("t5_byp_resp_id", 32'(resp_id), 32'd2);
        cyc();
        chk("t5_byp_no_start", 32'(start_cnt - s0), 32'd0);
`else
        chk("t5_div_start", 32'(div_start), 32'd1);
        wait_lat(lat);
        chk("t5_latency", 32'(lat), 32'd28);
        chk("t5_resp_q", resp_q, 32'h7F800000);
        chk("t5_resp_id", 32'(resp_id), 32'd2);
        cyc();
        chk("t5_one_start", 32'(start_cnt - s0), 32'd1);
`endif
        drain("t5_drain");

        // sparse requests with wrap: move pointer to 2, then requesters 3 and 1
        req_valid = 4'b0010;
        wait_grant(4'b0010, "t6_setup_grant1");
        cyc();
        req_valid = '0;
        drain("t6_setup_drain");
        op_n[3]   = 32'h40000000;
        op_d[3]   = 32'h3F800000;
        req_valid = 4'b1010;
        wait_grant(4'b1000, "t6_grant3");
        cyc();
        wait_grant(4'b0010, "t6_grant1_after_wrap");
        cyc();
        req_valid = 4'b1100;
        wait_grant(4'b0100, "t6_ptr_is_2");
        cyc();
        req_valid = '0;
        drain("t6_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
